// File: rtl/rca_pkg.sv
// Shared definitions for the chunked ripple-carry adder: FSM encoding and
// the sizing helper for the chunk index register.
package rca_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUSY = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    // ceil(log2(n)) with a floor of one bit so a single-chunk build still has an index
    function automatic int idx_width(input int n);
        int w;
        w = 1;
        while ((1 << w) < n) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/rca_chunk.sv
// Combinational W-bit ripple of full-adder cells; one chunk of the
// multi-cycle adder.
module rca_chunk #(
    parameter int W = 8
) (
    input  logic [W-1:0] x,
    input  logic [W-1:0] y,
    input  logic         ci,
    output logic [W-1:0] s,
    output logic         co
);

    logic [W:0] w_c;

    assign w_c[0] = ci;

    genvar gi;
    generate
        for (gi = 0; gi < W; gi++) begin : g_fa
            assign s[gi]      = x[gi] ^ y[gi] ^ w_c[gi];
            assign w_c[gi+1]  = (x[gi] & y[gi]) | (w_c[gi] & (x[gi] ^ y[gi]));
        end
    endgenerate

    assign co = w_c[W];

endmodule

// File: rtl/rca_chunk_add.sv
// Multi-cycle adder: sum = a + b + cin over G bits, W bits per clock, with the
// inter-chunk carry held in a flop. Valid/ready handshakes on both sides.
module rca_chunk_add
    import rca_pkg::*;
#(
    parameter int G = 32,
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [G-1:0] a,
    input  logic [G-1:0] b,
    input  logic         cin,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [G-1:0] sum,
    output logic         cout
);

    localparam int N  = G / W;
    localparam int IW = idx_width(N);
    localparam logic [IW-1:0] IDX_LAST = IW'(N - 1);

    generate
        if (W < 1 || (G % W) != 0) begin : g_bad_params
            $error("rca_chunk_add: G must be a positive multiple of W");
        end
    endgenerate

    logic [1:0]            r_state;
    logic [IW-1:0]         r_idx;
    logic                  r_carry;
    logic [N-1:0][W-1:0]   r_a;
    logic [N-1:0][W-1:0]   r_b;
    logic [N-1:0][W-1:0]   r_sum;

    logic [W-1:0]          w_s;
    logic                  w_co;
    logic                  w_accept;
    logic                  w_release;

    assign in_ready  = (r_state == ST_IDLE);
    assign out_valid = (r_state == ST_DONE);
    assign w_accept  = in_valid && in_ready;
    assign w_release = out_valid && out_ready;

    assign sum  = r_sum;
    assign cout = r_carry;

    // Single adder cell shared across chunks; idx steers the operand slices into it
    rca_chunk #(
        .W (W)
    ) u_chunk (
        .x  (r_a[r_idx]),
        .y  (r_b[r_idx]),
        .ci (r_carry),
        .s  (w_s),
        .co (w_co)
    );

    // Operand holding registers carry no control meaning, so they are not reset
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_a <= a;
            r_b <= b;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_idx   <= '0;
            r_carry <= 1'b0;
            r_sum   <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_carry <= cin;
                        r_idx   <= '0;
                        r_state <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    r_sum[r_idx] <= w_s;
                    r_carry      <= w_co;
                    // idx parks on the last chunk rather than wrapping
                    if (r_idx == IDX_LAST) begin
                        r_state <= ST_DONE;
                    end else begin
                        r_idx <= r_idx + 1'b1;
                    end
                end
                ST_DONE: begin
                    if (w_release) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rca_chunk_add.sv
// Directed and randomized bench for rca_chunk_add (G=32, W=8) against a plain
// arithmetic reference model.
module tb_rca_chunk_add;

    localparam int G = 32;
    localparam int W = 8;
    localparam int N = G / W;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [G-1:0]  a = '0;
    logic [G-1:0]  b = '0;
    logic          cin = 1'b0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [G-1:0]  sum;
    logic          cout;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    rca_chunk_add #(
        .G (G),
        .W (W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Runs one full transaction and checks result, latency and return to idle
    task automatic run_op(input string tag, input logic [G-1:0] op_a,
                          input logic [G-1:0] op_b, input logic op_cin,
                          output logic [G-1:0] got_sum);
        logic [G:0] ref_full;
        int lat;
        ref_full = {1'b0, op_a} + {1'b0, op_b} + {{G{1'b0}}, op_cin};
        @(negedge clk);
        chk({tag, ".in_ready"}, 64'(in_ready), 64'd1);
        in_valid = 1'b1;
        a = op_a;
        b = op_b;
        cin = op_cin;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        a = $urandom;
        b = $urandom;
        cin = 1'($urandom);
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        chk({tag, ".latency"}, 64'(lat), 64'(N));
        chk({tag, ".sum"}, 64'(sum), 64'(ref_full[G-1:0]));
        chk({tag, ".cout"}, 64'(cout), 64'(ref_full[G]));
        got_sum = sum;
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk({tag, ".idle_ready"}, 64'(in_ready), 64'd1);
        chk({tag, ".idle_valid"}, 64'(out_valid), 64'd0);
    endtask

    initial begin
        logic [G-1:0] r;
        logic [G:0]   ref_full;
        int           orig_a, sub_b, bin, diff;

        // Reset state
        #2;
        chk("rst.in_ready", 64'(in_ready), 64'd1);
        chk("rst.out_valid", 64'(out_valid), 64'd0);
        chk("rst.sum", 64'(sum), 64'd0);
        chk("rst.cout", 64'(cout), 64'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed cases
        run_op("small", 32'd25, 32'd7, 1'b1, r);
        run_op("all_ones", 32'hFFFF_FFFF, 32'd1, 1'b0, r);
        run_op("chunk_bnd", 32'h0000_00FF, 32'h0000_0001, 1'b0, r);
        run_op("mid_bnd", 32'h00FF_FFFF, 32'h0000_0000, 1'b1, r);

        // Back-pressure in DONE with a competing input request
        ref_full = {1'b0, 32'h8765_4321} + {1'b0, 32'h9ABC_DEF0} + 33'd1;
        @(negedge clk);
        in_valid = 1'b1;
        a = 32'h8765_4321;
        b = 32'h9ABC_DEF0;
        cin = 1'b1;
        @(posedge clk);
        #1;
        a = 32'h1111_1111;
        b = 32'h2222_2222;
        cin = 1'b0;
        for (int i = 0; i < N - 1; i++) begin
            @(posedge clk);
        end
        #1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            chk("bp.out_valid", 64'(out_valid), 64'd1);
            chk("bp.in_ready", 64'(in_ready), 64'd0);
            chk("bp.sum", 64'(sum), 64'(ref_full[G-1:0]));
            chk("bp.cout", 64'(cout), 64'(ref_full[G]));
        end
        in_valid = 1'b0;
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk("bp.released", 64'(out_valid), 64'd0);
        for (int i = 0; i < N + 2; i++) begin
            @(posedge clk);
            #1;
            chk("bp.not_taken", 64'(out_valid), 64'd0);
        end

        // Reset during the second BUSY cycle
        @(negedge clk);
        in_valid = 1'b1;
        a = 32'hFFFF_FFFF;
        b = 32'd1;
        cin = 1'b0;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("mrst.in_ready", 64'(in_ready), 64'd1);
        chk("mrst.out_valid", 64'(out_valid), 64'd0);
        chk("mrst.sum", 64'(sum), 64'd0);
        chk("mrst.cout", 64'(cout), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < N + 1; i++) begin
            @(posedge clk);
            #1;
            chk("mrst.no_output", 64'(out_valid), 64'd0);
        end
        run_op("after_rst", 32'd3, 32'd4, 1'b0, r);

        // Random full-range operands
        for (int i = 0; i < 10; i++) begin
            run_op("rand", 32'($urandom), 32'($urandom), 1'($urandom), r);
        end

        // Inverse of the subtractor: (a - b - bin) + b + bin == a
        for (int i = 0; i < 10; i++) begin
            orig_a = int'($urandom_range(30, 20));
            sub_b  = int'($urandom_range(10, 0));
            bin    = int'($urandom_range(1, 0));
            diff   = orig_a - sub_b - bin;
            run_op("inverse", 32'(diff), 32'(sub_b), 1'(bin), r);
            chk("inverse.orig", 64'(r), 64'(orig_a));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/rca_chunk_add.md
# rca_chunk_add

Multi-cycle ripple-carry adder that computes sum = a + b + cin over G-bit operands, W bits per clock, with the carry held in a flop between chunks. It is the inverse of the ripple-carry subtractor: given diff, b and bin from the subtractor, it returns the original a. It sits beside the subtractor in the arithmetic library and uses valid/ready handshakes on both sides, so it can run inside a stream datapath or as a self-checking companion in subtractor benches.

## Interface
- G, 32: operand and result width.
- W, 8: chunk width, i.e. bits added per cycle. Legal only when G % W == 0 and W >= 1; otherwise elaboration fails.
- N (local), G/W: number of chunks.

- clk  in  1  single clock; all state changes on the rising edge.
- rst_n  in  1  reset; one clock, reset is asynchronous and active-low.
- in_valid  in  1  operand set presented.
- in_ready  out  1  block can accept operands.
- a  in  G  addend.
- b  in  G  addend.
- cin  in  1  carry-in.
- out_valid  out  1  result available.
- out_ready  in  1  consumer accepts result.
- sum  out  G  (a + b + cin) mod 2^G.
- cout  out  1  carry-out of bit G-1.

## Operation
- States: IDLE, BUSY, DONE.
- **IDLE**
  - in_ready=1, out_valid=0.
  - On in_valid && in_ready: latch a, b and cin (cin goes into the carry flop), set idx=0, go to BUSY.
- **BUSY**
  - in_ready=0, out_valid=0.
  - Each cycle: {c, s} = a_r[idx*W +: W] + b_r[idx*W +: W] + carry.
  - Write s into sum_r[idx*W +: W], set carry <= c, set idx <= idx+1.
  - After the chunk with idx == N-1, go to DONE.
  - Input pins are not sampled.
- **DONE**
  - out_valid=1, in_ready=0.
  - sum and cout (the carry flop) are held stable until out_ready=1.
  - On out_valid && out_ready, go to IDLE.
- Arithmetic is unsigned modulo 2^G. Overflow shows only in cout. No saturation.
- idx is ceil(log2(N))-bit wide with a minimum of 1 bit. It never wraps past N-1.
- Simultaneous events:
  - in_valid during BUSY or DONE is ignored. The producer must hold its data.
  - The in_valid and out_ready handshake cannot coincide, because in_ready and out_valid are never both 1.
- Reset is asynchronous and can be asserted in any state, including mid-BUSY or mid-DONE.
  - Effect: state=IDLE, idx=0, carry=0, sum_r=0.
  - Any operation in flight is discarded and produces no output.

## Timing
- Reset values: in_ready=1, out_valid=0, sum=0, cout=0.
- An input handshake at edge k gives out_valid=1 from edge k+N onward.
  - With G=32 and W=8, out_valid rises 4 cycles after accept.
  - With W=G, out_valid rises 1 cycle after accept.
- in_ready returns to 1 the cycle after the output handshake edge. The minimum initiation interval is N+2 cycles.
- sum and cout are registered and have no combinational path from the inputs.
- in_ready and out_valid are decoded from the state register only.
- Intermediate sum chunks may be visible on sum during BUSY. Consumers qualify sum with out_valid.

## Structure
- Package rca_pkg holds:
  - the state encoding (IDLE=2'd0, BUSY=2'd1, DONE=2'd2);
  - a function giving the idx width from N.
- Sub-module rca_chunk: a combinational W-bit ripple of full-adder cells built with a generate loop.
  - Ports: x[W], y[W], ci, s[W], co.
  - The top instantiates it once and muxes the chunk selected by idx into it.

## Test plan
With G=32, W=8:
- a=25, b=7, cin=1 → sum=33, cout=0; out_valid exactly 4 cycles after accept.
- a=0xFFFF_FFFF, b=1, cin=0 → sum=0, cout=1. The carry ripples through all 4 chunks.
- a=0x0000_00FF, b=0x0000_0001, cin=0 → sum=0x0000_0100, cout=0. Checks the chunk-boundary carry.
- out_ready held low for 5 cycles in DONE, with in_valid pulsed and new operands presented → sum and cout unchanged, in_ready=0, the new operands are not taken; the first op completes normally after out_ready.
- rst_n pulsed low during the 2nd BUSY cycle of a=0xFFFF_FFFF + 1 → outputs immediately at reset values; a following op a=3, b=4, cin=0 gives sum=7, cout=0.
- Inverse check, 10 random pairs with a in 20..30, b in 0..10, bin random: the subtractor gives diff; then feed this block a=diff, b=b, cin=bin → sum equals the original a, cout=0 (e.g. 27 − 4 − 1 = 22, then 22 + 4 + 1 = 27).
